// File: rtl/evt_fifo_pkg.sv
// Shared types and helpers for the event FIFO serializer: state encoding,
// derived-width functions and a saturating counter increment.
package evt_fifo_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int nslice(input int dwidth, input int slice_w);
    return (dwidth + slice_w - 1) / slice_w;
  endfunction

  function automatic int numel_w(input int depth);
    return $clog2(depth + 2);
  endfunction

  // Holds at the all-ones value of a width-bit counter instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/evt_fifo_mem.sv
// Circular event-word store with wrap-bit pointers, combinational head and
// pop strobe. Callers qualify push/pop; flush empties it in one cycle.
module evt_fifo_mem #(
  parameter int DWIDTH = 136,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DWIDTH-1:0]        wdata,
  output logic [DWIDTH-1:0]        head,
  output logic [$clog2(DEPTH):0]   mem_count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: flops use non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign mem_count = wr_ptr_q - rd_ptr_q;
  assign full      = (mem_count == (AW + 1)'(DEPTH));

endmodule

// File: rtl/evt_fifo_serializer.sv
// Event FIFO readout: stages one word at a time and hands it out in SLICE_W
// slices on shift_en, with prefetch, hysteretic IRQ and saturating counters.
module evt_fifo_serializer
  import evt_fifo_pkg::*;
#(
  parameter int DWIDTH    = 136,
  parameter int DEPTH     = 16,
  parameter int SLICE_W   = 16,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 8,
  localparam int NSLICE   = nslice(DWIDTH, SLICE_W),
  localparam int NUMEL_W  = numel_w(DEPTH),
  localparam int IDX_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               wr_en,
  input  logic [DWIDTH-1:0]  wdata,
  output logic               full,
  output logic               empty,
  output logic [NUMEL_W-1:0] numel,
  input  logic               shift_en,
  output logic [SLICE_W-1:0] rdata_slice,
  output logic [IDX_W-1:0]   slice_idx,
  output logic               word_valid,
  output logic               last_slice,
  input  logic [NUMEL_W-1:0] irq_assert_thresh,
  input  logic [NUMEL_W-1:0] irq_deassert_thresh,
  output logic               irq,
  output logic [CNT_W-1:0]   ovf_cnt,
  output logic [CNT_W-1:0]   udf_cnt
);

  localparam int MC_W  = $clog2(DEPTH) + 1;
  localparam int PAD_W = NSLICE * SLICE_W;
  localparam logic [0:0]       ST_IDLE  = IDLE;
  localparam logic [0:0]       ST_SHIFT = SHIFT;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [0:0]        state_q, state_d;
  logic [DWIDTH-1:0] staged_q, staged_d;
  logic [IDX_W-1:0]  slice_idx_q, slice_idx_d;
  logic              irq_q, irq_d;
  logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0]  udf_cnt_q, udf_cnt_d;

  logic [DWIDTH-1:0] head;
  logic [MC_W-1:0]   mem_count;
  logic              mem_full, has_data, push, pop, ovf_evt, udf_evt;
  logic [PAD_W-1:0]  padded;

  evt_fifo_mem #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_mem (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .wdata     (wdata),
    .head      (head),
    .mem_count (mem_count),
    .full      (mem_full)
  );

  assign word_valid = (state_q == ST_SHIFT);
  assign last_slice = word_valid && (slice_idx_q == LAST_IDX);
  assign slice_idx  = slice_idx_q;
  assign has_data   = (mem_count != '0);
  assign numel      = NUMEL_W'(mem_count) + NUMEL_W'(word_valid);
  assign empty      = (numel == '0);
  assign full       = mem_full;
  assign irq        = irq_q;
  assign ovf_cnt    = ovf_cnt_q;
  assign udf_cnt    = udf_cnt_q;

  always_comb begin
    state_d     = state_q;
    staged_d    = staged_q;
    slice_idx_d = slice_idx_q;
    pop         = 1'b0;
    if (flush) begin
      state_d     = ST_IDLE;
      staged_d    = '0;
      slice_idx_d = '0;
    end else if (state_q == ST_IDLE) begin
      if (has_data) begin
        pop         = 1'b1;
        staged_d    = head;
        slice_idx_d = '0;
        state_d     = ST_SHIFT;
      end
    end else if (shift_en) begin
      if (!last_slice) begin
        slice_idx_d = slice_idx_q + IDX_ONE;
      end else begin
        slice_idx_d = '0;
        // Prefetch the next word on the final shift so word_valid never drops.
        if (has_data) begin
          pop      = 1'b1;
          staged_d = head;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // A write into a full store is still accepted when a pop frees a slot this cycle.
  assign push    = wr_en && !flush && (!mem_full || pop);
  assign ovf_evt = wr_en && !flush && mem_full && !pop;
  assign udf_evt = shift_en && !flush && !word_valid;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    udf_cnt_d = udf_cnt_q;
    if (cnt_clr) begin
      ovf_cnt_d = '0;
      udf_cnt_d = '0;
    end else begin
      if (ovf_evt) ovf_cnt_d = CNT_W'(sat_inc(32'(ovf_cnt_q), CNT_W));
      if (udf_evt) udf_cnt_d = CNT_W'(sat_inc(32'(udf_cnt_q), CNT_W));
    end
  end

  always_comb begin
    if (numel >= irq_assert_thresh)        irq_d = 1'b1;
    else if (numel <= irq_deassert_thresh) irq_d = 1'b0;
    else                                   irq_d = irq_q;
  end

  assign padded = PAD_W'(staged_q);

  always_comb begin
    rdata_slice = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (slice_idx_q == IDX_W'(k))
        rdata_slice = padded[((MSB_FIRST != 0) ? (NSLICE - 1 - k) : k) * SLICE_W +: SLICE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      staged_q    <= '0;
      slice_idx_q <= '0;
      irq_q       <= 1'b0;
      ovf_cnt_q   <= '0;
      udf_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      staged_q    <= staged_d;
      slice_idx_q <= slice_idx_d;
      irq_q       <= irq_d;
      ovf_cnt_q   <= ovf_cnt_d;
      udf_cnt_q   <= udf_cnt_d;
    end
  end

endmodule

// File: tb/tb_evt_fifo_serializer.sv
// Self-checking bench: an MSB-first and an LSB-first instance share stimulus
// and are compared each cycle against a queue-based model plus literal pins.
module tb_evt_fifo_serializer;

  localparam int DW = 136, DEPTH = 16, SW = 16, CW = 8, NS = 9, NW = 5, IW = 4;
  localparam int PW = NS * SW;
  localparam logic [DW-1:0] W1 = 136'hAB_1111_2222_3333_4444_5555_6666_77AB_CDEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, cnt_clr, wr_en, shift_en;
  logic [DW-1:0] wdata;
  logic [NW-1:0] ath, dth;

  logic          a_full, a_empty, a_wv, a_last, a_irq;
  logic [NW-1:0] a_numel;
  logic [SW-1:0] a_rd;
  logic [IW-1:0] a_idx;
  logic [CW-1:0] a_ovf, a_udf;
  logic          b_full, b_empty, b_wv, b_last, b_irq;
  logic [NW-1:0] b_numel;
  logic [SW-1:0] b_rd;
  logic [IW-1:0] b_idx;
  logic [CW-1:0] b_ovf, b_udf;

  evt_fifo_serializer u_a (
    .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr), .wr_en(wr_en), .wdata(wdata),
    .full(a_full), .empty(a_empty), .numel(a_numel), .shift_en(shift_en),
    .rdata_slice(a_rd), .slice_idx(a_idx), .word_valid(a_wv), .last_slice(a_last),
    .irq_assert_thresh(ath), .irq_deassert_thresh(dth), .irq(a_irq),
    .ovf_cnt(a_ovf), .udf_cnt(a_udf)
  );

  evt_fifo_serializer #(.MSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr), .wr_en(wr_en), .wdata(wdata),
    .full(b_full), .empty(b_empty), .numel(b_numel), .shift_en(shift_en),
    .rdata_slice(b_rd), .slice_idx(b_idx), .word_valid(b_wv), .last_slice(b_last),
    .irq_assert_thresh(ath), .irq_deassert_thresh(dth), .irq(b_irq),
    .ovf_cnt(b_ovf), .udf_cnt(b_udf)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] slice_of(input logic [DW-1:0] w, input int k, input bit msb);
    logic [PW-1:0] p;
    int o;
    p = PW'(w);
    o = msb ? (NS - 1 - k) : k;
    return p[o*SW +: SW];
  endfunction

  function automatic logic [DW-1:0] mkw(input int i);
    logic [31:0] s;
    s = 32'h1357_9BDF ^ (32'(i) * 32'h0103_0507);
    return {8'(i + 1), s, ~s, s + 32'd1, s ^ 32'hFFFF_0000};
  endfunction

  // Model: storage queue, the word being read out, its slice position, irq and counters.
  logic [DW-1:0] mq[$];
  bit            m_sv = 0;
  logic [DW-1:0] m_stage = '0;
  int            m_idx = 0;
  bit            m_irq = 0;
  int            m_ovf = 0, m_udf = 0;
  bit            m_started = 0;

  always @(posedge clk) begin
    int  n;
    bit  popped, sv_old, full_now, ovf_ev, udf_ev;
    m_started = 1;
    if (rst) begin
      mq.delete();
      m_sv = 0; m_stage = '0; m_idx = 0; m_irq = 0; m_ovf = 0; m_udf = 0;
    end else begin
      n        = mq.size() + int'(m_sv);
      sv_old   = m_sv;
      full_now = (mq.size() == DEPTH);
      popped   = 0;
      ovf_ev   = 0;
      udf_ev   = 0;
      if (n >= int'(ath))      m_irq = 1;
      else if (n <= int'(dth)) m_irq = 0;
      if (flush) begin
        mq.delete();
        m_sv = 0; m_stage = '0; m_idx = 0;
      end else begin
        if (!sv_old) begin
          if (mq.size() > 0) begin
            m_stage = mq.pop_front(); m_sv = 1; m_idx = 0; popped = 1;
          end
        end else if (shift_en) begin
          if (m_idx == NS - 1) begin
            m_idx = 0;
            if (mq.size() > 0) begin
              m_stage = mq.pop_front(); popped = 1;
            end else m_sv = 0;
          end else m_idx++;
        end
        udf_ev = shift_en && !sv_old;
        if (wr_en) begin
          if (!full_now || popped) mq.push_back(wdata);
          else ovf_ev = 1;
        end
      end
      if (cnt_clr) begin
        m_ovf = 0; m_udf = 0;
      end else begin
        if (ovf_ev && m_ovf < 255) m_ovf++;
        if (udf_ev && m_udf < 255) m_udf++;
      end
    end
  end

  task automatic cmp_inst(input string p, input logic f, input logic e, input logic [NW-1:0] nm,
                          input logic wv, input logic ls, input logic [IW-1:0] ix,
                          input logic [SW-1:0] rd, input logic iq, input logic [CW-1:0] ov,
                          input logic [CW-1:0] ud, input bit msb);
    int n;
    n = mq.size() + int'(m_sv);
    check({p, "_full"},  PW'(f),  PW'(mq.size() == DEPTH));
    check({p, "_empty"}, PW'(e),  PW'(n == 0));
    check({p, "_numel"}, PW'(nm), PW'(n));
    check({p, "_wv"},    PW'(wv), PW'(m_sv));
    check({p, "_last"},  PW'(ls), PW'(m_sv && m_idx == NS - 1));
    check({p, "_idx"},   PW'(ix), PW'(m_idx));
    check({p, "_rdata"}, PW'(rd), PW'(slice_of(m_stage, m_idx, msb)));
    check({p, "_irq"},   PW'(iq), PW'(m_irq));
    check({p, "_ovf"},   PW'(ov), PW'(m_ovf));
    check({p, "_udf"},   PW'(ud), PW'(m_udf));
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      cmp_inst("a", a_full, a_empty, a_numel, a_wv, a_last, a_idx, a_rd, a_irq, a_ovf, a_udf, 1'b1);
      cmp_inst("b", b_full, b_empty, b_numel, b_wv, b_last, b_idx, b_rd, b_irq, b_ovf, b_udf, 1'b0);
    end
  end

  task automatic drive(input logic we, input logic [DW-1:0] d, input logic se,
                       input logic fl, input logic cc);
    wr_en = we; wdata = d; shift_en = se; flush = fl; cnt_clr = cc;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic shift(input int n);
    repeat (n) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  logic [SW-1:0] t1_exp [NS] = '{16'h00AB, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                                 16'h5555, 16'h6666, 16'h77AB, 16'hCDEF};

  initial begin
    logic [PW-1:0] acc;
    logic [DW-1:0] w1v;
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0; wr_en = 1'b0; shift_en = 1'b0;
    wdata = '0; ath = 5'd31; dth = 5'd0;
    repeat (2) @(negedge clk);
    check("rst_empty", PW'(a_empty), PW'(1));
    check("rst_full",  PW'(a_full),  PW'(0));
    check("rst_numel", PW'(a_numel), PW'(0));
    check("rst_wv",    PW'(a_wv),    PW'(0));
    check("rst_rdata", PW'(a_rd),    PW'(0));
    rst = 1'b0;

    // Single word, MSB-first slicing with top-slice zero padding.
    drive(1'b1, W1, 1'b0, 1'b0, 1'b0);
    check("t1_numel_wr", PW'(a_numel), PW'(1));
    check("t1_wv_wr",    PW'(a_wv),    PW'(0));
    idle(1);
    check("t1_wv",     PW'(a_wv), PW'(1));
    check("t1_b_rd0",  PW'(b_rd), PW'(16'hCDEF));
    for (int k = 0; k < NS; k++) begin
      check("t1_slice", PW'(a_rd),   PW'(t1_exp[k]));
      check("t1_last",  PW'(a_last), PW'(k == NS - 1));
      shift(1);
    end
    check("t1_wv_end",    PW'(a_wv),    PW'(0));
    check("t1_numel_end", PW'(a_numel), PW'(0));

    // Three words streamed back to back with shift_en held.
    for (int i = 0; i < 3; i++) drive(1'b1, mkw(i), 1'b0, 1'b0, 1'b0);
    idle(1);
    check("t2_numel", PW'(a_numel), PW'(3));
    acc = '0;
    for (int c = 0; c < 3 * NS; c++) begin
      check("t2_wv",  PW'(a_wv),  PW'(1));
      check("t2_idx", PW'(a_idx), PW'(c % NS));
      acc = {acc[PW-SW-1:0], a_rd};
      if (c % NS == NS - 1) check("t2_word", acc, PW'(mkw(c / NS)));
      shift(1);
    end
    check("t2_numel_end", PW'(a_numel), PW'(0));

    // Overflow at full, then write accepted alongside a pop.
    for (int i = 0; i < 18; i++) drive(1'b1, mkw(10 + i), 1'b0, 1'b0, 1'b0);
    idle(1);
    check("t3_numel", PW'(a_numel), PW'(17));
    check("t3_full",  PW'(a_full),  PW'(1));
    check("t3_ovf",   PW'(a_ovf),   PW'(1));
    shift(NS - 1);
    drive(1'b1, mkw(99), 1'b1, 1'b0, 1'b0);
    check("t3_ovf_pop",   PW'(a_ovf),   PW'(1));
    check("t3_numel_pop", PW'(a_numel), PW'(17));
    check("t3_full_pop",  PW'(a_full),  PW'(1));

    // IRQ hysteresis: set at 12, hold down to 5, clear at 4.
    ath = 5'd12; dth = 5'd4;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t4_flush_numel", PW'(a_numel), PW'(0));
    for (int i = 0; i < 12; i++) drive(1'b1, mkw(40 + i), 1'b0, 1'b0, 1'b0);
    check("t4_numel12", PW'(a_numel), PW'(12));
    check("t4_irq_pre", PW'(a_irq),   PW'(0));
    idle(1);
    check("t4_irq_set", PW'(a_irq), PW'(1));
    shift(7 * NS);
    check("t4_numel5", PW'(a_numel), PW'(5));
    idle(1);
    check("t4_irq_hold", PW'(a_irq), PW'(1));
    shift(NS);
    check("t4_numel4", PW'(a_numel), PW'(4));
    idle(1);
    check("t4_irq_clr", PW'(a_irq), PW'(0));

    // Flush mid-word with a concurrent write.
    for (int i = 0; i < 6; i++) drive(1'b1, mkw(60 + i), 1'b0, 1'b0, 1'b0);
    shift(5);
    check("t5_idx",   PW'(a_idx),   PW'(5));
    check("t5_numel", PW'(a_numel), PW'(10));
    drive(1'b1, mkw(200), 1'b0, 1'b1, 1'b0);
    check("t5_numel_fl", PW'(a_numel), PW'(0));
    check("t5_wv_fl",    PW'(a_wv),    PW'(0));
    check("t5_idx_fl",   PW'(a_idx),   PW'(0));
    check("t5_ovf_fl",   PW'(a_ovf),   PW'(1));

    // Underflow, LSB-first mapping, reset mid-word.
    ath = 5'd31; dth = 5'd0;
    shift(2);
    check("t6_udf", PW'(b_udf), PW'(2));
    drive(1'b1, W1, 1'b0, 1'b0, 1'b0);
    idle(1);
    shift(3);
    check("t6_b_idx", PW'(b_idx), PW'(3));
    check("t6_b_rd3", PW'(b_rd),  PW'(16'h5555));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t6_rst_numel", PW'(b_numel), PW'(0));
    check("t6_rst_empty", PW'(b_empty), PW'(1));
    check("t6_rst_wv",    PW'(b_wv),    PW'(0));
    check("t6_rst_rd",    PW'(b_rd),    PW'(0));
    check("t6_rst_udf",   PW'(b_udf),   PW'(0));
    check("t6_rst_ovf",   PW'(a_ovf),   PW'(0));
    w1v = W1;
    drive(1'b1, W1, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("t6_b_slice0", PW'(b_rd), PW'(w1v[15:0]));

    // Counter saturation and clear-wins-over-event.
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    shift(260);
    check("sat_udf", PW'(a_udf), PW'(255));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("clr_udf", PW'(a_udf), PW'(0));

    // Assert threshold 0 raises irq on the first cycle out of reset.
    ath = 5'd0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("irq0_in_rst", PW'(a_irq), PW'(0));
    idle(1);
    check("irq0_set", PW'(a_irq), PW'(1));
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
